// File: rtl/pipelined_register_file_if.sv
// Bus bundle for the pipelined register file: read selects/data, write-back,
// PC control and scoreboard issue/busy signals.
interface pipelined_register_file_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic [AW-1:0] SA;
  logic [AW-1:0] SB;
  logic [AW-1:0] SD;
  logic [DW-1:0] PA;
  logic [DW-1:0] PB;
  logic [DW-1:0] PD;
  logic [AW-1:0] C;
  logic [DW-1:0] PW;
  logic          RFLd;
  logic [DW-1:0] PCin;
  logic          PCLd;
  logic          PCEn;
  logic [DW-1:0] PCout;
  logic          IssLd;
  logic [AW-1:0] IssDst;
  logic          BusyA;
  logic          BusyB;
  logic          BusyD;
  logic          Hazard;

  modport master (
    output SA, SB, SD, C, PW, RFLd, PCin, PCLd, PCEn, IssLd, IssDst,
    input  PA, PB, PD, PCout, BusyA, BusyB, BusyD, Hazard
  );

  modport slave (
    input  SA, SB, SD, C, PW, RFLd, PCin, PCLd, PCEn, IssLd, IssDst,
    output PA, PB, PD, PCout, BusyA, BusyB, BusyD, Hazard
  );
endinterface

// File: rtl/pipelined_register_file.sv
// NREG x DW register file with three bypassed read ports, one write-back port,
// a PC in the top register and a per-register busy scoreboard for RAW detection.
module pipelined_register_file #(
  parameter int              DW       = 32,
  parameter int              NREG     = 16,
  parameter int              AW       = 4,
  parameter int unsigned     PC_INC   = 4,
  parameter logic [DW-1:0]   RESET_PC = '0
) (
  input logic                      CLK,
  input logic                      RSTn,
  pipelined_register_file_if.slave bus
);

  localparam int PC_IDX = NREG - 1;
  localparam int NPORT  = 3;

  logic [DW-1:0]   r_reg  [NREG];
  logic [DW-1:0]   r_next [NREG];
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] wr_hit;
  logic [NREG-1:0] iss_hit;

  logic [AW-1:0] rd_sel  [NPORT];
  logic [DW-1:0] rd_data [NPORT];
  logic          rd_busy [NPORT];

  genvar gi;

  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      assign wr_hit[gi]  = bus.RFLd  && (bus.C      == AW'(gi));
      assign iss_hit[gi] = bus.IssLd && (bus.IssDst == AW'(gi));

      // A same-edge issue outranks the write-back clear: the new producer is still in flight.
      assign busy_next[gi] = iss_hit[gi] | (busy_reg[gi] & ~wr_hit[gi]);

      if (gi == PC_IDX) begin : g_pc
        assign r_next[gi] = wr_hit[gi] ? bus.PW :
                            bus.PCLd   ? bus.PCin :
                            bus.PCEn   ? r_reg[gi] + DW'(PC_INC) :
                                         r_reg[gi];
      end else begin : g_gpr
        assign r_next[gi] = wr_hit[gi] ? bus.PW : r_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < PC_IDX; i++) begin
        r_reg[i] <= '0;
      end
      r_reg[PC_IDX] <= RESET_PC;
      busy_reg      <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        r_reg[i] <= r_next[i];
      end
      busy_reg <= busy_next;
    end
  end

  assign rd_sel[0] = bus.SA;
  assign rd_sel[1] = bus.SB;
  assign rd_sel[2] = bus.SD;

  // Reads forward the write-back value, and a forwarded read never reports busy.
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_port
      logic byp;
      assign byp          = bus.RFLd && (bus.C == rd_sel[gi]);
      assign rd_data[gi]  = byp ? bus.PW : r_reg[rd_sel[gi]];
      assign rd_busy[gi]  = busy_reg[rd_sel[gi]] & ~byp;
    end
  endgenerate

  assign bus.PA     = rd_data[0];
  assign bus.PB     = rd_data[1];
  assign bus.PD     = rd_data[2];
  assign bus.BusyA  = rd_busy[0];
  assign bus.BusyB  = rd_busy[1];
  assign bus.BusyD  = rd_busy[2];
  assign bus.Hazard = rd_busy[0] | rd_busy[1] | rd_busy[2];
  assign bus.PCout  = r_reg[PC_IDX];

endmodule
